// File: rtl/cplx_accum_ctrl.sv
// cplx_accum_ctrl: sequences the complex adder datapath for one tap-sum.
// Accepts len complex samples over valid/ready and sums them with
// guard-bit-extended adds. Returns the sum plus a sticky per-job overflow flag.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   start, len          job start pulse (IDLE only) and sample count
//   in_valid/in_ready   input sample handshake; in_re/in_im Q(QI).(QF)
//   out_valid/out_ready result handshake; out_re/out_im Q(QI+GUARD).(QF)
//   overflow            sticky wrap/saturation indicator for the job
//   busy                high whenever the sequencer is not IDLE
//
// Build option: define CPLX_ACCUM_SAT_EN to saturate on overflow
// instead of wrapping modulo 2^A.
module cplx_accum_ctrl #(
    parameter int QI    = 3,
    parameter int QF    = 3,
    parameter int GUARD = 4,
    parameter int N_MAX = 16,
    localparam int W    = QI + QF,
    localparam int A    = QI + GUARD + QF,
    localparam int CW   = $clog2(N_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_re,
    input  logic [W-1:0]  in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [A-1:0]  out_re,
    output logic [A-1:0]  out_im,
    output logic          overflow,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [A-1:0]  acc_re, acc_re_n;
    logic [A-1:0]  acc_im, acc_im_n;
    logic [CW-1:0] count, count_n;
    logic [CW-1:0] len_q, len_q_n;
    logic          ovf, ovf_n;

    logic [CW-1:0] len_clamp;
    logic [A-1:0]  ext_re, ext_im;
    logic [A:0]    sum_re, sum_im;
    logic [CW-1:0] count_inc;

    // Returns {overflow, sum}. Overflow is the classic same-sign-in,
    // different-sign-out test on the A-bit result.
    function automatic logic [A:0] add_ovf(
        input logic [A-1:0] a,
        input logic [A-1:0] b
    );
        logic [A-1:0] s;
        logic         o;
        s = a + b;
        o = (a[A-1] == b[A-1]) && (s[A-1] != a[A-1]);
`ifdef CPLX_ACCUM_SAT_EN
        if (o) begin
            s = a[A-1] ? {1'b1, {(A-1){1'b0}}}
                       : {1'b0, {(A-1){1'b1}}};
        end
`endif
        return {o, s};
    endfunction

    assign len_clamp = (len > CW'(N_MAX)) ? CW'(N_MAX) : len;

    assign ext_re = {{(A-W){in_re[W-1]}}, in_re};
    assign ext_im = {{(A-W){in_im[W-1]}}, in_im};

    assign sum_re = add_ovf(acc_re, ext_re);
    assign sum_im = add_ovf(acc_im, ext_im);

    assign count_inc = count + 1'b1;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_re    = acc_re;
    assign out_im    = acc_im;
    assign overflow  = ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc_re <= '0;
            acc_im <= '0;
            count  <= '0;
            len_q  <= '0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_n;
            acc_re <= acc_re_n;
            acc_im <= acc_im_n;
            count  <= count_n;
            len_q  <= len_q_n;
            ovf    <= ovf_n;
        end
    end

    always_comb begin
        state_n  = state;
        acc_re_n = acc_re;
        acc_im_n = acc_im;
        count_n  = count;
        len_q_n  = len_q;
        ovf_n    = ovf;
        unique case (state)
            IDLE: begin
                if (start) begin
                    len_q_n  = len_clamp;
                    acc_re_n = '0;
                    acc_im_n = '0;
                    count_n  = '0;
                    ovf_n    = 1'b0;
                    // A zero-length job goes straight to a zero result.
                    state_n  = (len_clamp == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_re_n = sum_re[A-1:0];
                    acc_im_n = sum_im[A-1:0];
                    ovf_n    = ovf | sum_re[A] | sum_im[A];
                    count_n  = count_inc;
                    if (count_inc == len_q) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                // start is deliberately not looked at here, so a start
                // coinciding with the result handshake is dropped.
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cplx_accum_ctrl.sv
// Directed bench for cplx_accum_ctrl: default instance plus a GUARD=1
// instance sharing the same stimulus for the overflow case.
module tb_cplx_accum_ctrl;

    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          in_valid;
    logic [5:0]    in_re, in_im;
    logic          out_ready;

    logic          in_ready, out_valid, overflow, busy;
    logic [9:0]    out_re, out_im;

    logic          g_in_ready, g_out_valid, g_overflow, g_busy;
    logic [6:0]    g_out_re, g_out_im;

    int checks = 0;
    int errors = 0;
    int exp_sat;

    always #5 clk = ~clk;

    cplx_accum_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im),
        .overflow(overflow), .busy(busy)
    );

    cplx_accum_ctrl #(.GUARD(1)) u_g1 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(g_in_ready),
        .in_re(in_re), .in_im(in_im),
        .out_valid(g_out_valid), .out_ready(out_ready),
        .out_re(g_out_re), .out_im(g_out_im),
        .overflow(g_overflow), .busy(g_busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves at the negedge after the start edge.
    task automatic go(input int n);
        start = 1'b1;
        len   = CW'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one sample and returns at the negedge after its accept.
    task automatic send(input int re, input int im);
        int t = 0;
        in_valid = 1'b1;
        in_re    = 6'(re);
        in_im    = 6'(im);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0;
        in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_ovalid", out_valid, 0);
        check("rst_re", $signed(out_re), 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic sum and one-cycle latency.
        go(3);
        send(8, 4);
        send(16, 4);
        check("t1_pre_valid", out_valid, 0);
        send(-4, 4);
        check("t1_valid", out_valid, 1);
        check("t1_re", $signed(out_re), 20);
        check("t1_im", $signed(out_im), 12);
        check("t1_ovf", overflow, 0);
        collect();
        check("t1_idle_valid", out_valid, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_re", $signed(out_re), 20);

        // Overflow: wraps to -35 on A=7, or saturates to 63.
`ifdef CPLX_ACCUM_SAT_EN
        exp_sat = 63;
`else
        exp_sat = -35;
`endif
        go(3);
        send(31, 0);
        send(31, 0);
        check("t2_g1_mid_ovf", g_overflow, 0);
        send(31, 0);
        check("t2_g1_re", $signed(g_out_re), exp_sat);
        check("t2_g1_ovf", g_overflow, 1);
        check("t2_re", $signed(out_re), 93);
        check("t2_ovf", overflow, 0);
        collect();
        check("t2_g1_hold_ovf", g_overflow, 1);

        // Input gaps.
        go(4);
        for (int i = 0; i < 4; i++) begin
            send(1, -1);
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    check("t3_gap_ready", in_ready, 1);
                    @(negedge clk);
                end
            end
        end
        check("t3_re", $signed(out_re), 4);
        check("t3_im", $signed(out_im), -4);
        check("t3_g1_ovf_clr", g_overflow, 0);
        collect();

        // Result backpressure with stray start pulses.
        go(1);
        send(2, 3);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 5'd5;
            check("t4_valid", out_valid, 1);
            check("t4_busy", busy, 1);
            check("t4_re", $signed(out_re), 2);
            check("t4_im", $signed(out_im), 3);
            @(negedge clk);
        end
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        check("t4_idle_busy", busy, 0);
        check("t4_idle_valid", out_valid, 0);
        check("t4_idle_re", $signed(out_re), 2);

        // Zero length job.
        go(0);
        check("t5_valid", out_valid, 1);
        check("t5_re", $signed(out_re), 0);
        check("t5_im", $signed(out_im), 0);
        collect();

        // Length clamp to 16.
        go(20);
        for (int i = 0; i < 15; i++) send(1, 0);
        check("t6_ready15", in_ready, 1);
        send(1, 0);
        check("t6_ready16", in_ready, 0);
        check("t6_valid", out_valid, 1);
        check("t6_re", $signed(out_re), 16);
        collect();

        // Reset mid-job.
        go(4);
        send(3, 3);
        send(3, 3);
        rst = 1'b1;
        #1;
        check("t7_rst_re", $signed(out_re), 0);
        check("t7_rst_im", $signed(out_im), 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_ready", in_ready, 0);
        check("t7_rst_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        go(1);
        send(5, 5);
        check("t7_valid", out_valid, 1);
        check("t7_re", $signed(out_re), 5);
        check("t7_im", $signed(out_im), 5);
        check("t7_ovf", overflow, 0);
        collect();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
